uart_rx_fifo: RTL and testbench

//  Receive buffer directly downstream of the UART receiver. Captures each byte strobed by the

---
 rtl/uart_rx_fifo.sv | 125 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: show-ahead circular buffer with fill level and sticky overflow.
// Define UART_RX_FIFO_FLOW_EN to build the XOFF/XON software flow-control requester.
module uart_rx_fifo #(
    parameter int DEPTH   = 16,
    parameter int HI_MARK = DEPTH - 4,
    parameter int LO_MARK = 4
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_Rx_DV,
    input  logic [7:0]               i_Rx_Byte,
    input  logic                     i_Rd_En,
    output logic [7:0]               o_Rd_Data,
    output logic                     o_Empty,
    output logic                     o_Full,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic                     o_Overflow,
    input  logic                     i_Clr_Overflow,
    output logic                     o_Flow_Req,
    output logic [7:0]               o_Flow_Byte,
    input  logic                     i_Flow_Ack
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          push, pop;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a write.
    assign pop  = i_Rd_En && !o_Empty;
    assign push = i_Rx_DV && (!o_Full || pop);

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CW'(1);
        else if (pop && !push)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge i_Clock) begin
        if (push && !i_Reset)
            mem[wr_ptr] <= i_Rx_Byte;
    end

    assign o_Rd_Data = mem[rd_ptr];
    assign o_Count   = count;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_Empty    <= 1'b1;
            o_Full     <= 1'b0;
            o_Overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count   <= count_nxt;
            o_Empty <= (count_nxt == '0);
            o_Full  <= (count_nxt == CW'(DEPTH));
            // A dropped byte wins over a clear arriving in the same cycle.
            if (i_Rx_DV && !push)
                o_Overflow <= 1'b1;
            else if (i_Clr_Overflow)
                o_Overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_FLOW_EN
    localparam logic [CW-1:0] HI_C = CW'(HI_MARK);
    localparam logic [CW-1:0] LO_C = CW'(LO_MARK);
    localparam logic [7:0]    XOFF = 8'h13;
    localparam logic [7:0]    XON  = 8'h11;

    typedef enum logic [1:0] {FLOW_ON, SEND_XOFF, FLOW_OFF, SEND_XON} flow_t;
    flow_t flow_st;

    // Once a send starts it is held until acknowledged, whatever the level does meanwhile.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            flow_st     <= FLOW_ON;
            o_Flow_Req  <= 1'b0;
            o_Flow_Byte <= 8'h00;
        end else begin
            case (flow_st)
                FLOW_ON: if (count >= HI_C) begin
                    flow_st     <= SEND_XOFF;
                    o_Flow_Req  <= 1'b1;
                    o_Flow_Byte <= XOFF;
                end
                SEND_XOFF: if (i_Flow_Ack) begin
                    flow_st    <= FLOW_OFF;
                    o_Flow_Req <= 1'b0;
                end
                FLOW_OFF: if (count <= LO_C) begin
                    flow_st     <= SEND_XON;
                    o_Flow_Req  <= 1'b1;
                    o_Flow_Byte <= XON;
                end
                SEND_XON: if (i_Flow_Ack) begin
                    flow_st    <= FLOW_ON;
                    o_Flow_Req <= 1'b0;
                end
                default: begin
                    flow_st    <= FLOW_ON;
                    o_Flow_Req <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_flow;
    assign unused_flow = i_Flow_Ack ^ (HI_MARK > LO_MARK);
    assign o_Flow_Req  = 1'b0;
    assign o_Flow_Byte = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int HI    = DEPTH - 4;
    localparam int LO    = 4;

    logic       clk = 1'b0;
    logic       rst, dv, rd, clr, ack;
    logic [7:0] din;
    logic [7:0] rd_data, flow_byte;
    logic       empty, full, ovf, flow_req;
    logic [4:0] cnt;

    always #5 clk = ~clk;

    uart_rx_fifo dut (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(dv), .i_Rx_Byte(din),
        .i_Rd_En(rd), .o_Rd_Data(rd_data), .o_Empty(empty), .o_Full(full),
        .o_Count(cnt), .o_Overflow(ovf), .i_Clr_Overflow(clr),
        .o_Flow_Req(flow_req), .o_Flow_Byte(flow_byte), .i_Flow_Ack(ack)
    );

    // Reference state: contents as a queue, flow control as "paused" plus a pending request.
    logic [7:0] q[$];
    bit         m_ovf, m_req, m_paused;
    logic [7:0] m_fbyte;
    int         n_chk = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int n;
        bit p, w;
        n = q.size();
        p = rd && (n > 0);
        w = dv && ((n < DEPTH) || p);
        if (rst) begin
            q.delete();
            m_ovf = 0; m_req = 0; m_paused = 0; m_fbyte = 8'h00;
            return;
        end
        if (m_req) begin
            if (ack) begin
                m_req    = 0;
                m_paused = (m_fbyte == 8'h13);
            end
        end else if (!m_paused && n >= HI) begin
            m_req = 1; m_fbyte = 8'h13;
        end else if (m_paused && n <= LO) begin
            m_req = 1; m_fbyte = 8'h11;
        end
        if (dv && !w) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (p) void'(q.pop_front());
        if (w) q.push_back(din);
    endtask

    task automatic check_all();
        chk("count", cnt, q.size());
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == DEPTH);
        chk("overflow", ovf, m_ovf);
        if (q.size() > 0) chk("rd_data", rd_data, q[0]);
`ifdef UART_RX_FIFO_FLOW_EN
        chk("flow_req", flow_req, m_req);
        chk("flow_byte", flow_byte, m_fbyte);
`else
        chk("flow_req_off", flow_req, 0);
        chk("flow_byte_off", flow_byte, 0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        rst = 0; dv = 0; rd = 0; clr = 0; ack = 0; din = 8'h00;
    endtask

    task automatic wr(input logic [7:0] b);
        dv = 1; din = b; step(); dv = 0;
    endtask

    task automatic pop();
        rd = 1; step(); rd = 0;
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk); model_edge();
        do_reset();
        chk("rst_count", cnt, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_req", flow_req, 0);
        chk("rst_fbyte", flow_byte, 0);

        // In-order write and read-back
        wr(8'h41); wr(8'h42); wr(8'h43);
        chk("t1_count", cnt, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_data", rd_data, 8'h41 + i);
            pop();
        end
        chk("t1_empty", empty, 1);
        chk("t1_count0", cnt, 0);

        // Overflow drops the extra byte
        do_reset();
        for (int i = 0; i < 16; i++) wr(8'(i));
        wr(8'h99);
        chk("t2_full", full, 1);
        chk("t2_ovf", ovf, 1);
        chk("t2_count", cnt, 16);
        for (int i = 0; i < 16; i++) begin
            chk("t2_data", rd_data, i);
            pop();
        end
        chk("t2_empty", empty, 1);
        clr = 1; step(); clr = 0;
        chk("t2_clr", ovf, 0);

        // Write and pop together while full
        do_reset();
        for (int i = 0; i < 16; i++) wr(8'h20 + 8'(i));
        dv = 1; din = 8'h55; rd = 1; step(); dv = 0; rd = 0;
        chk("t3_count", cnt, 16);
        chk("t3_head", rd_data, 8'h21);
        chk("t3_ovf", ovf, 0);
        for (int i = 0; i < 15; i++) begin
            chk("t3_data", rd_data, 8'h21 + i);
            pop();
        end
        chk("t3_last", rd_data, 8'h55);
        pop();
        chk("t3_empty", empty, 1);

        // Pops on empty are ignored
        do_reset();
        for (int i = 0; i < 5; i++) pop();
        chk("t4_count", cnt, 0);
        chk("t4_empty", empty, 1);
        wr(8'h7E);
        chk("t4_data", rd_data, 8'h7E);
        chk("t4_count1", cnt, 1);

        // Reset during a write discards everything
        for (int i = 0; i < 4; i++) wr(8'hB0 + 8'(i));
        dv = 1; din = 8'hCC; rst = 1; step(); dv = 0; rst = 0;
        chk("t5_count", cnt, 0);
        chk("t5_empty", empty, 1);
        chk("t5_ovf", ovf, 0);
        wr(8'hA5);
        chk("t5_data", rd_data, 8'hA5);
        chk("t5_count1", cnt, 1);

        // Flow control thresholds
        do_reset();
        for (int i = 0; i < HI; i++) wr(8'h60 + 8'(i));
        step();
`ifdef UART_RX_FIFO_FLOW_EN
        for (int i = 0; i < 3; i++) begin
            chk("t6_xoff_req", flow_req, 1);
            chk("t6_xoff_byte", flow_byte, 8'h13);
            step();
        end
        ack = 1; step(); ack = 0;
        chk("t6_xoff_drop", flow_req, 0);
        for (int i = 0; i < HI - LO; i++) pop();
        chk("t6_lo_count", cnt, LO);
        step();
        chk("t6_xon_req", flow_req, 1);
        chk("t6_xon_byte", flow_byte, 8'h11);
        ack = 1; step(); ack = 0;
        chk("t6_xon_drop", flow_req, 0);
`else
        for (int i = 0; i < 4; i++) begin
            chk("t6_noflow_req", flow_req, 0);
            step();
        end
`endif

        // Random traffic with alternating fill/drain bias
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int pdv, prd;
            pdv = ((c / 250) % 2 == 0) ? 70 : 30;
            prd = ((c / 250) % 2 == 0) ? 30 : 70;
            dv  = ($urandom_range(99) < pdv);
            din = 8'($urandom);
            rd  = ($urandom_range(99) < prd);
            clr = ($urandom_range(99) < 3);
            ack = m_req ? ($urandom_range(3) == 0) : ($urandom_range(99) < 2);
            rst = ($urandom_range(999) < 3);
            step();
        end
        idle();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
